// File: rtl/fb_write_sched_pkg.sv
// Shared types and defaults for the framebuffer write scheduler.
// The state enum is also exported on the top as a debug output.
package fb_sched_pkg;

    localparam int FB_WORDS_DEFAULT   = 9600;
    localparam int STARVE_MAX_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_write_sched_if.sv
// Host Avalon-MM write port of the framebuffer scheduler.
// Handshake: a write transfers on a rising edge where chipselect & write
// are high and waitrequest is low; otherwise the host holds its request.
interface fb_write_sched_if #(
    parameter int ADDR_W = 15
);
    logic [31:0]       writedata;
    logic              write;
    logic              chipselect;
    logic [ADDR_W-1:0] address;
    logic              waitrequest;

    modport master (
        output writedata, write, chipselect, address,
        input  waitrequest
    );

    modport slave (
        input  writedata, write, chipselect, address,
        output waitrequest
    );
endinterface

// File: rtl/fb_write_sched_fill_counter.sv
// Fill address/count datapath: latches the (wrapped) base and length,
// steps the address with wrap at FB_WORDS-1 and flags the last word.
module fb_fill_counter
    import fb_sched_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int FB_WORDS = FB_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W-1:0] base_wrapped;

    // Out-of-range bases fold back into the framebuffer when latched.
    assign base_wrapped = ADDR_W'(32'(base) % 32'(FB_WORDS));

    // Address and remaining-word count; a step consumes one word.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (load) begin
            addr_q      <= base_wrapped;
            remaining_q <= len;
        end else if (step) begin
            addr_q      <= (addr_q == ADDR_W'(FB_WORDS - 1)) ? '0 : addr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
        end
    end

    assign addr = addr_q;
    assign last = (remaining_q == (ADDR_W+1)'(1));

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: arbitrates host writes against a pattern
// fill engine onto a single registered RAM write port.
// Optional feature: define FB_VBLANK_ONLY_EN to restrict fill writes to
// vertical blanking (host is stalled during vblank while a fill is pending).
module fb_write_sched
    import fb_sched_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int FB_WORDS   = FB_WORDS_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    fb_write_sched_if.slave   host,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [31:0]       fill_pattern,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              vblank,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    output fb_state_e         fsm_state
);

    fb_state_e         state_q, state_d;
    logic              host_req, host_grant, fill_grant, fill_pending;
    logic              cnt_load, cnt_last;
    logic [ADDR_W-1:0] cnt_addr;
    logic [31:0]       pattern_q;

    assign cnt_load  = (state_q == IDLE) && fill_start && (fill_len != '0);
    assign fsm_state = state_q;

    fb_fill_counter #(
        .ADDR_W   (ADDR_W),
        .FB_WORDS (FB_WORDS)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .base  (fill_base),
        .len   (fill_len),
        .step  (fill_grant),
        .addr  (cnt_addr),
        .last  (cnt_last)
    );

`ifdef FB_VBLANK_ONLY_EN
    // Starvation guard is not needed: vblank alone decides who writes.
    always_comb begin
        fill_pending     = (state_q == FILL);
        host_req         = host.chipselect & host.write;
        host.waitrequest = fill_pending & vblank;
        host_grant       = host_req & ~host.waitrequest;
        fill_grant       = fill_pending & vblank;
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q;
    logic          unused_vblank;

    assign unused_vblank = vblank;

    // Arbitration: host first, fill takes idle cycles or a forced slot.
    always_comb begin
        fill_pending     = (state_q == FILL);
        host_req         = host.chipselect & host.write;
        host.waitrequest = fill_pending & (starve_q == SW'(STARVE_MAX));
        host_grant       = host_req & ~host.waitrequest;
        fill_grant       = fill_pending & ~host_grant;
    end

    // Consecutive host grants while a fill waits; cleared by a fill grant.
    always_ff @(posedge clk) begin
        if (reset || state_q != FILL || fill_grant) begin
            starve_q <= '0;
        end else if (host_grant && starve_q < SW'(STARVE_MAX)) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; fill_start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fill_start) state_d = (fill_len != '0) ? FILL : DONE;
            FILL: if (fill_grant && cnt_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        fill_busy = (state_q == FILL) || (state_q == DONE);
        fill_done = (state_q == DONE);
    end

    // Fill pattern is captured with the command so the input may change.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= '0;
        end else if (cnt_load) begin
            pattern_q <= fill_pattern;
        end
    end

    // Registered RAM write port: the winner of this cycle writes next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
        end else if (host_grant) begin
            ram_wren      <= 1'b1;
            ram_wraddress <= host.address;
            ram_data      <= host.writedata;
        end else if (fill_grant) begin
            ram_wren      <= 1'b1;
            ram_wraddress <= cnt_addr;
            ram_data      <= pattern_q;
        end else begin
            ram_wren      <= 1'b0;
        end
    end

endmodule
